midi_out: RTL

MIDI_OUT -- requirements
Module: midi_out

---
 rtl/midi_out.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/midi_out.sv
`default_nettype none
// ============================================================================
// Module      : midi_out
// Description : MIDI transmitter. Queues whole channel/system messages in a
//               small FIFO and serialises them on a 31.25 kbaud-style line
//               clocked at one baud_clk edge per bit, with optional running
//               status and an optional idle gap between messages.
// Revision    : 1.0 - initial release
// ============================================================================
module midi_out #(
    parameter int RUNNING_STATUS = 1,
    parameter int FIFO_DEPTH     = 4,
    parameter int GAP_BITS       = 0
) (
    input  logic       baud_clk,
    input  logic       rst,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] status_out,
    input  logic [7:0] data1_out,
    input  logic [7:0] data2_out,
    input  logic [1:0] bytes_cnt_out,
    output logic       midi_tx,
    output logic       busy,
    output logic       err_drop
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_GAP_W-1:0] c_GAP_INIT = c_GAP_W'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    // Queue storage and bookkeeping
    logic [25:0]        r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Serialiser state
    state_t             r_state;
    logic               r_tx;
    logic [7:0]         r_shift;
    logic [7:0]         r_next1;
    logic [7:0]         r_next2;
    logic [1:0]         r_bytes_left;
    logic [2:0]         r_bit_idx;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [7:0]         r_last_status;
    logic               r_err_drop;

    logic               w_accept;
    logic               w_bad;
    logic               w_push;
    logic               w_pop;
    logic               w_omit;
    logic [25:0]        w_head;
    logic [1:0]         w_head_cnt;
    logic [7:0]         w_head_st;
    logic [7:0]         w_head_d1;
    logic [7:0]         w_head_d2;

    // Ready depends on stored occupancy only, never on a same-cycle pop.
    assign msg_ready = (r_count < c_DEPTH);
    assign w_accept  = msg_valid & msg_ready;
    // Malformed messages (no bytes, or first byte not a status) are dropped.
    assign w_bad     = (bytes_cnt_out == 2'd0) | ~status_out[7];
    assign w_push    = w_accept & ~w_bad;
    assign w_pop     = (r_state == IDLE) && (r_count != '0);

    assign w_head     = r_fifo_mem[r_rd_ptr];
    assign w_head_cnt = w_head[25:24];
    assign w_head_st  = w_head[23:16];
    assign w_head_d1  = w_head[15:8];
    assign w_head_d2  = w_head[7:0];

    // A channel-voice status equal to the previous one is skipped, but a
    // single-byte message always keeps its status so it never becomes empty.
    assign w_omit = (RUNNING_STATUS != 0) && (w_head_st <= 8'hEF) &&
                    (w_head_st == r_last_status) && (w_head_cnt > 2'd1);

    assign midi_tx  = r_tx;
    assign busy     = (r_state != IDLE) || (r_count != '0);
    assign err_drop = r_err_drop;

    // Message storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge baud_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {bytes_cnt_out, status_out, data1_out, data2_out};
        end
    end

    // Queue pointers and occupancy; a simultaneous push and pop cancel out.
    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Drop indication, one cycle after the rejected message was accepted.
    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            r_err_drop <= 1'b0;
        end else begin
            r_err_drop <= w_accept & w_bad;
        end
    end

    // Serialiser: pops a message, frames each byte start/8 data LSB first/stop.
    always_ff @(posedge baud_clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_tx          <= 1'b1;
            r_shift       <= '0;
            r_next1       <= '0;
            r_next2       <= '0;
            r_bytes_left  <= '0;
            r_bit_idx     <= '0;
            r_gap_cnt     <= '0;
            r_last_status <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_state <= START;
                        r_tx    <= 1'b0;
                        if (w_omit) begin
                            r_shift      <= w_head_d1;
                            r_next1      <= w_head_d2;
                            r_next2      <= w_head_d2;
                            r_bytes_left <= w_head_cnt - 2'd2;
                        end else begin
                            r_shift      <= w_head_st;
                            r_next1      <= w_head_d1;
                            r_next2      <= w_head_d2;
                            r_bytes_left <= w_head_cnt - 2'd1;
                        end
                        // Queued statuses always have bit 7 set.
                        if (w_head_st <= 8'hEF) begin
                            r_last_status <= w_head_st;
                        end else if (w_head_st <= 8'hF7) begin
                            r_last_status <= 8'h00;
                        end
                    end
                end
                START: begin
                    r_state   <= DATA;
                    r_bit_idx <= 3'd0;
                    r_tx      <= r_shift[0];
                    r_shift   <= {1'b0, r_shift[7:1]};
                end
                DATA: begin
                    if (r_bit_idx == 3'd7) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                    end
                end
                STOP: begin
                    if (r_bytes_left != 2'd0) begin
                        r_state      <= START;
                        r_tx         <= 1'b0;
                        r_shift      <= r_next1;
                        r_next1      <= r_next2;
                        r_bytes_left <= r_bytes_left - 2'd1;
                    end else if (GAP_BITS > 0) begin
                        r_state   <= GAP;
                        r_tx      <= 1'b1;
                        r_gap_cnt <= c_GAP_INIT;
                    end else begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                    end
                end
                GAP: begin
                    r_tx <= 1'b1;
                    if (r_gap_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
